// File: rtl/mux_nto1_reg.sv
// mux_nto1_reg: N:1 multiplexer with registered output, valid flag and channel
// tag, plus an auto-scan mode that round-robins the channels with a fixed
// number of enabled cycles (dwell) spent on each one.
module mux_nto1_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH*CHANNELS-1:0] mux_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          mux_out,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    output logic                      sel_err
);

    // Dwell counter needs at least one bit even when DWELL is 1.
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    // Wrap points: the pointer wraps at CHANNELS-1, not at 2**SEL_W-1, so a
    // non-power-of-two channel count still cycles through valid channels only.
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
    localparam logic [DW_W-1:0]  LAST_DW  = DW_W'(DWELL - 1);
    localparam logic [31:0]      CH_COUNT = CHANNELS;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [SEL_W-1:0] scan_ptr;
    logic [DW_W-1:0]  dwell_cnt;
    logic [SEL_W-1:0] base_ptr;
    logic [DW_W-1:0]  base_dwell;
    logic [SEL_W-1:0] next_ptr;
    logic [DW_W-1:0]  next_dwell;
    logic [SEL_W-1:0] chan;
    logic [WIDTH-1:0] chan_data;
    logic             sel_ok;

    // State register follows mode every cycle, independent of the enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MANUAL;
        end else begin
            state <= next_state;
        end
    end

    // Next state, scan base/advance values and the channel picked this cycle.
    // On the cycle that enters scan the base is forced to channel 0 with a
    // fresh dwell, so every scan session starts from the beginning.
    always_comb begin
        next_state = mode ? SCAN : MANUAL;
        base_ptr   = (state == MANUAL) ? '0 : scan_ptr;
        base_dwell = (state == MANUAL) ? '0 : dwell_cnt;
        next_ptr   = base_ptr;
        next_dwell = base_dwell + DW_W'(1);
        if (base_dwell == LAST_DW) begin
            next_dwell = '0;
            next_ptr   = (base_ptr == LAST_CH) ? '0 : base_ptr + SEL_W'(1);
        end
        chan   = mode ? base_ptr : sel;
        sel_ok = (32'(sel) < CH_COUNT);
    end

    // Channel data lookup; an index outside the populated channels reads as 0.
    always_comb begin
        chan_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (chan == SEL_W'(k)) begin
                chan_data = mux_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output registers and scan counters: updated only on enabled samples,
    // except out_valid which drops whenever no new word is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_out   <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            scan_ptr  <= '0;
            dwell_cnt <= '0;
        end else if (en) begin
            if (!mode) begin
                scan_ptr  <= '0;
                dwell_cnt <= '0;
                out_sel   <= sel;
                if (sel_ok) begin
                    mux_out   <= chan_data;
                    out_valid <= 1'b1;
                    sel_err   <= 1'b0;
                end else begin
                    mux_out   <= '0;
                    out_valid <= 1'b0;
                    sel_err   <= 1'b1;
                end
            end else begin
                mux_out   <= chan_data;
                out_sel   <= chan;
                out_valid <= 1'b1;
                sel_err   <= 1'b0;
                scan_ptr  <= next_ptr;
                dwell_cnt <= next_dwell;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// tb_mux_nto1_reg: directed checks of the registered N:1 mux on two builds,
// a 4-channel/dwell-2 instance and a 3-channel/dwell-1 instance.
module tb_mux_nto1_reg;

    logic        clk;
    logic        rst;

    logic [15:0] mux_in;
    logic [1:0]  sel;
    logic        mode;
    logic        en;
    logic [3:0]  mux_out;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        sel_err;

    logic [11:0] mux_in3;
    logic [1:0]  sel3;
    logic        mode3;
    logic        en3;
    logic [3:0]  mux_out3;
    logic [1:0]  out_sel3;
    logic        out_valid3;
    logic        sel_err3;

    int total;
    int bad;

    mux_nto1_reg #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(2)) dut (
        .clk(clk), .rst(rst), .mux_in(mux_in), .sel(sel), .mode(mode), .en(en),
        .mux_out(mux_out), .out_sel(out_sel), .out_valid(out_valid), .sel_err(sel_err)
    );

    mux_nto1_reg #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(1)) dut3 (
        .clk(clk), .rst(rst), .mux_in(mux_in3), .sel(sel3), .mode(mode3), .en(en3),
        .mux_out(mux_out3), .out_sel(out_sel3), .out_valid(out_valid3), .sel_err(sel_err3)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total++;
        if ({mux_out, out_sel, out_valid, sel_err} !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_state: got %02h expected 00",
                     {mux_out, out_sel, out_valid, sel_err});
        end
        total++;
        if ({mux_out3, out_sel3, out_valid3, sel_err3} !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_state3: got %02h expected 00",
                     {mux_out3, out_sel3, out_valid3, sel_err3});
        end
        rst = 1'b0;
        step();
    endtask

    // Channel k of 16'hF3A5 is nibble k: ch0=5, ch1=A, ch2=3, ch3=F.
    task automatic test_manual();
        logic [3:0] exp_data [4];
        exp_data[0] = 4'h5;
        exp_data[1] = 4'hA;
        exp_data[2] = 4'h3;
        exp_data[3] = 4'hF;
        mux_in = 16'hF3A5;
        mode   = 1'b0;
        en     = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            sel = 2'(i);
            step();
            total++;
            if ({mux_out, out_sel, out_valid, sel_err} !== {exp_data[i], 2'(i), 1'b1, 1'b0}) begin
                bad++;
                $display("[TB] FAIL manual_sel%0d: got data=%h sel=%0d v=%b err=%b expected data=%h sel=%0d v=1 err=0",
                         i, mux_out, out_sel, out_valid, sel_err, exp_data[i], i);
            end
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({mux_out, out_sel, out_valid, sel_err} !== 8'h00) begin
            bad++;
            $display("[TB] FAIL async_reset: got %02h expected 00",
                     {mux_out, out_sel, out_valid, sel_err});
        end
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic test_enable_gating();
        mux_in = 16'hF3A5;
        mode   = 1'b0;
        en     = 1'b1;
        sel    = 2'd1;
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i + 2);
            step();
            total++;
            if ({mux_out, out_sel, out_valid} !== {4'hA, 2'd1, 1'b0}) begin
                bad++;
                $display("[TB] FAIL en_hold%0d: got data=%h sel=%0d v=%b expected data=a sel=1 v=0",
                         i, mux_out, out_sel, out_valid);
            end
        end
    endtask

    // Channel k of 16'h4321 carries the value k+1.
    task automatic test_scan_wrap();
        int exp_ch [10];
        exp_ch = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        mux_in = 16'h4321;
        mode   = 1'b1;
        en     = 1'b1;
        sel    = 2'd3;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if ({mux_out, out_sel, out_valid, sel_err} !== {4'(exp_ch[i] + 1), 2'(exp_ch[i]), 1'b1, 1'b0}) begin
                bad++;
                $display("[TB] FAIL scan_wrap%0d: got data=%h sel=%0d v=%b err=%b expected data=%0d sel=%0d v=1 err=0",
                         i, mux_out, out_sel, out_valid, sel_err, exp_ch[i] + 1, exp_ch[i]);
            end
        end
    endtask

    task automatic test_scan_freeze();
        int exp_ch [9];
        logic [1:0] exp_v [9];
        exp_ch = '{0, 0, 1, 1, 1, 1, 2, 2, 0};
        exp_v  = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
        mux_in = 16'h4321;
        mode   = 1'b0;
        en     = 1'b1;
        sel    = 2'd0;
        step();
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en = (i == 3 || i == 4) ? 1'b0 : 1'b1;
            step();
            total++;
            if ({mux_out, out_sel, out_valid} !== {4'(exp_ch[i] + 1), 2'(exp_ch[i]), exp_v[i][0]}) begin
                bad++;
                $display("[TB] FAIL scan_freeze%0d: got data=%h sel=%0d v=%b expected data=%0d sel=%0d v=%0d",
                         i, mux_out, out_sel, out_valid, exp_ch[i] + 1, exp_ch[i], exp_v[i]);
            end
        end
        // Leave scan for one idle cycle, then come back: must restart at 0.
        mode = 1'b0;
        en   = 1'b0;
        step();
        mode = 1'b1;
        en   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_sel !== 2'(exp_ch[i])) begin
                bad++;
                $display("[TB] FAIL scan_restart%0d: got sel=%0d expected sel=%0d",
                         i, out_sel, exp_ch[i]);
            end
        end
        // Reset in the middle of a scan, then resume scanning from channel 0.
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({mux_out, out_sel, out_valid, sel_err} !== 8'h00) begin
            bad++;
            $display("[TB] FAIL scan_reset: got %02h expected 00",
                     {mux_out, out_sel, out_valid, sel_err});
        end
        #2;
        rst = 1'b0;
        step();
        total++;
        if ({mux_out, out_sel, out_valid} !== {4'h1, 2'd0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL scan_after_reset: got data=%h sel=%0d v=%b expected data=1 sel=0 v=1",
                     mux_out, out_sel, out_valid);
        end
        mode = 1'b0;
        en   = 1'b0;
    endtask

    // Three-channel build: 12'h321 gives ch0=1, ch1=2, ch2=3.
    task automatic test_out_of_range();
        mux_in3 = 12'h321;
        mode3   = 1'b0;
        en3     = 1'b1;
        sel3    = 2'd3;
        step();
        total++;
        if ({mux_out3, out_sel3, out_valid3, sel_err3} !== {4'h0, 2'd3, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL oor_sel3: got data=%h sel=%0d v=%b err=%b expected data=0 sel=3 v=0 err=1",
                     mux_out3, out_sel3, out_valid3, sel_err3);
        end
        en3  = 1'b0;
        sel3 = 2'd0;
        step();
        total++;
        if ({out_valid3, sel_err3} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL oor_hold: got v=%b err=%b expected v=0 err=1", out_valid3, sel_err3);
        end
        en3  = 1'b1;
        sel3 = 2'd1;
        step();
        total++;
        if ({mux_out3, out_sel3, out_valid3, sel_err3} !== {4'h2, 2'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL oor_clear: got data=%h sel=%0d v=%b err=%b expected data=2 sel=1 v=1 err=0",
                     mux_out3, out_sel3, out_valid3, sel_err3);
        end
    endtask

    task automatic test_scan_dwell1();
        int exp_ch [5];
        exp_ch  = '{0, 1, 2, 0, 1};
        mux_in3 = 12'h321;
        mode3   = 1'b1;
        en3     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({mux_out3, out_sel3, out_valid3} !== {4'(exp_ch[i] + 1), 2'(exp_ch[i]), 1'b1}) begin
                bad++;
                $display("[TB] FAIL scan3_%0d: got data=%h sel=%0d v=%b expected data=%0d sel=%0d v=1",
                         i, mux_out3, out_sel3, out_valid3, exp_ch[i] + 1, exp_ch[i]);
            end
        end
        en3 = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        mux_in  = '0;
        sel     = '0;
        mode    = 1'b0;
        en      = 1'b0;
        mux_in3 = '0;
        sel3    = '0;
        mode3   = 1'b0;
        en3     = 1'b0;
        test_reset();
        test_manual();
        test_async_reset();
        test_enable_gating();
        test_scan_wrap();
        test_scan_freeze();
        test_out_of_range();
        test_scan_dwell1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
